// File: rtl/inst_fetch.sv
// inst_fetch: IF stage with a direct-mapped one-word I-cache and a byte-serial miss refill.
// Define ICACHE_EN to build the cache arrays; without it every fetch takes the refill path.
module inst_fetch #(
    parameter int ICACHE_LINES = 128,
    parameter int IDX_W = 7
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] pc_in,
    input  logic        pre_to_take_in,
    input  logic [5:0]  stall,
    input  logic        incorrect,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        stallreq,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        pre_to_take_out
);
    typedef enum logic [2:0] {IDLE, WAIT, B0, B1, B2, B3, B4} state_t;
    state_t state;
    logic [31:0] fetch_pc;
    logic [7:0] b0, b1, b2;
    logic hit;
    logic [31:0] hit_data;
    logic [31:0] fill;
    logic unused_stall;
    assign fill = {mem_din, b2, b1, b0};
    assign unused_stall = ^{stall[5:2], stall[0]};
    // The B3 cycle delivers the word directly, so the PC stage may advance then.
    assign stallreq = !hit && !(state == B3 && fetch_pc == pc_in);
`ifdef ICACHE_EN
    localparam int TAG_W = 16 - IDX_W;
    logic [ICACHE_LINES-1:0] valid;
    logic [TAG_W-1:0] tags [ICACHE_LINES];
    logic [31:0] lines [ICACHE_LINES];
    logic [IDX_W-1:0] idx, fill_idx;
    logic wr;
    assign idx = pc_in[IDX_W+1:2];
    assign fill_idx = fetch_pc[IDX_W+1:2];
    assign hit = valid[idx] && tags[idx] == pc_in[17:IDX_W+2];
    assign hit_data = lines[idx];
    assign wr = rdy_in && !incorrect && state == B3;
    always_ff @(posedge clk_in)
        if (rst_in) valid <= '0;
        else if (wr) valid[fill_idx] <= 1'b1;
    always_ff @(posedge clk_in)
        if (wr) begin
            tags[fill_idx] <= fetch_pc[17:IDX_W+2];
            lines[fill_idx] <= fill;
        end
`else
    logic unused_cfg;
    assign hit = 1'b0;
    assign hit_data = '0;
    assign unused_cfg = (ICACHE_LINES != 0) ^ (IDX_W != 0);
`endif
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            fetch_pc <= '0;
            b0 <= '0;
            b1 <= '0;
            b2 <= '0;
            mem_req <= 1'b0;
            mem_addr <= '0;
            inst_out <= '0;
            pc_out <= '0;
            pre_to_take_out <= 1'b0;
        end else if (rdy_in) begin
            if (incorrect) begin
                state <= IDLE;
                mem_req <= 1'b0;
                inst_out <= '0;
                pc_out <= '0;
                pre_to_take_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (!hit) begin
                        fetch_pc <= pc_in;
                        mem_req <= 1'b1;
                        state <= WAIT;
                    end
                    WAIT: if (mem_grant) begin
                        mem_addr <= fetch_pc;
                        state <= B0;
                    end
                    B0: begin
                        b0 <= mem_din;
                        mem_addr <= fetch_pc + 32'd1;
                        state <= B1;
                    end
                    B1: begin
                        b1 <= mem_din;
                        mem_addr <= fetch_pc + 32'd2;
                        state <= B2;
                    end
                    B2: begin
                        b2 <= mem_din;
                        mem_addr <= fetch_pc + 32'd3;
                        state <= B3;
                    end
                    B3: begin
                        mem_req <= 1'b0;
                        state <= B4;
                        if (!stall[1]) begin
                            inst_out <= fill;
                            pc_out <= fetch_pc;
                            pre_to_take_out <= pre_to_take_in;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (hit && !stall[1]) begin
                    inst_out <= hit_data;
                    pc_out <= pc_in;
                    pre_to_take_out <= pre_to_take_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scoreboard bench for inst_fetch with a byte memory and grant model.
module tb_inst_fetch;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, pre_to_take_in, incorrect, mem_grant;
    logic mem_req, stallreq, pre_to_take_out;
    logic [31:0] pc_in, mem_addr, inst_out, pc_out;
    logic [5:0] stall;
    logic [7:0] mem_din;
    logic [7:0] mem [1024];
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic pre;
    } exp_t;
    exp_t sb[$];
    logic [127:0] mv;
    logic [8:0] mtag [128];
    logic [31:0] last_inst, last_pc;
    logic last_pre;
    int n_chk = 0, n_fail = 0;

    inst_fetch dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc_in(pc_in),
        .pre_to_take_in(pre_to_take_in), .stall(stall), .incorrect(incorrect),
        .mem_grant(mem_grant), .mem_din(mem_din), .mem_req(mem_req), .mem_addr(mem_addr),
        .stallreq(stallreq), .inst_out(inst_out), .pc_out(pc_out), .pre_to_take_out(pre_to_take_out)
    );

    always #5 clk_in = ~clk_in;
    always_comb mem_din = mem[mem_addr[9:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [31:0] pc);
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = pc + 32'(k);
            word[8*k +: 8] = mem[a[9:0]];
        end
    endfunction

    function automatic bit hitm(input logic [31:0] pc);
`ifdef ICACHE_EN
        return mv[pc[8:2]] && mtag[pc[8:2]] == pc[17:9];
`else
        return 1'b0;
`endif
    endfunction

    // kind: 0 plain, 1 redirect, 2 reset, 3 rdy_in freeze; applied once 'at' refill addresses are seen
    task automatic fetch(input logic [31:0] pc, input logic pre, input int gdelay,
                         input bit hold, input int kind, input int at);
        bit miss, done;
        int naddr, nreq, k;
        logic pg;
        exp_t e;
        miss = !hitm(pc);
        pc_in = pc;
        pre_to_take_in = pre;
        stall = hold ? 6'b000010 : 6'b000000;
        e = hold ? '{last_inst, last_pc, last_pre} : '{word(pc), pc, pre};
        sb.push_back(e);
        naddr = 0;
        nreq = 0;
        done = 0;
        k = kind;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (mem_req) nreq++;
            mem_grant = mem_req && nreq > gdelay;
            #1;
            check("stallreq", 32'(stallreq), 32'(miss && naddr < 4));
            if (k != 0 && naddr == at) begin
                if (k == 3) begin
                    rdy_in = 1'b0;
                    tick();
                    tick();
                    check("freeze_addr", mem_addr, pc + 32'(naddr - 1));
                    check("freeze_req", 32'(mem_req), 32'd1);
                    rdy_in = 1'b1;
                    k = 0;
                    continue;
                end
                if (k == 1) incorrect = 1'b1;
                else rst_in = 1'b1;
                tick();
                incorrect = 1'b0;
                rst_in = 1'b0;
                mem_grant = 1'b0;
                check("abort_req", 32'(mem_req), 32'd0);
                check("abort_inst", inst_out, 32'd0);
                check("abort_pc", pc_out, 32'd0);
                check("abort_pre", 32'(pre_to_take_out), 32'd0);
                if (k == 2) begin
                    check("reset_addr", mem_addr, 32'd0);
                    mv = '0;
                end
                void'(sb.pop_front());
                last_inst = '0;
                last_pc = '0;
                last_pre = 1'b0;
                return;
            end
            if (!stallreq) begin
                done = 1;
                break;
            end
            pg = mem_grant;
            tick();
            if (pg && naddr < 4) begin
                check("mem_addr", mem_addr, pc + 32'(naddr));
                naddr++;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $error("FAIL timeout: pc %h got no output expected one within 40 cycles", pc);
            return;
        end
        tick();
        mem_grant = 1'b0;
        e = sb.pop_front();
        check("inst_out", inst_out, e.inst);
        check("pc_out", pc_out, e.pc);
        check("pre_out", 32'(pre_to_take_out), 32'(e.pre));
        check("req_idle", 32'(mem_req), 32'd0);
        check("refill_bytes", 32'(naddr), miss ? 32'd4 : 32'd0);
        last_inst = e.inst;
        last_pc = e.pc;
        last_pre = e.pre;
        if (miss) begin
            mv[pc[8:2]] = 1'b1;
            mtag[pc[8:2]] = pc[17:9];
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'h10;
        mem[3] = 8'h00;
        mv = '0;
        last_inst = '0;
        last_pc = '0;
        last_pre = 1'b0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        pc_in = '0;
        pre_to_take_in = 1'b0;
        stall = '0;
        incorrect = 1'b0;
        mem_grant = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_inst", inst_out, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_pre", 32'(pre_to_take_out), 32'd0);
        rst_in = 1'b0;
        check("cold_word", word(32'h0), 32'h00100513);
        fetch(32'h0, 1'b0, 2, 1'b0, 0, 0);
        fetch(32'h0, 1'b1, 0, 1'b0, 0, 0);
        fetch(32'h200, 1'b0, 1, 1'b0, 0, 0);
        fetch(32'h0, 1'b0, 0, 1'b0, 0, 0);
        fetch(32'h0, 1'b1, 0, 1'b1, 0, 0);
        fetch(32'h4, 1'b0, 1, 1'b1, 0, 0);
        fetch(32'h0, 1'b0, 0, 1'b0, 0, 0);
        fetch(32'h40, 1'b0, 1, 1'b0, 1, 2);
        fetch(32'h40, 1'b1, 1, 1'b0, 0, 0);
        fetch(32'h80, 1'b0, 0, 1'b0, 3, 2);
        fetch(32'hFFFFFFFE, 1'b1, 0, 1'b0, 0, 0);
        fetch(32'h100, 1'b0, 1, 1'b0, 2, 3);
        fetch(32'h0, 1'b0, 0, 1'b0, 0, 0);
        fetch(32'h0, 1'b1, 0, 1'b0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly downstream of the PC/BTB stage: takes the current fetch PC and its predicted-taken flag and returns the 32-bit instruction word to the IF/ID latch.
- Serves hits from a direct-mapped instruction cache.
- On a miss, reads the word byte by byte from the memory controller through a request/grant handshake, assembles it little-endian, and fills the cache.
- Requests a pipeline stall while a miss is outstanding; aborts cleanly on branch redirect.

Parameters:
ICACHE_LINES, 128, number of one-word cache lines (power of two)
IDX_W, 7, log2(ICACHE_LINES); index = pc[IDX_W+1:2], tag = pc[17:IDX_W+2]

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; when low, all state and outputs hold
pc_in  input  32  fetch PC from PC stage
pre_to_take_in  input  1  BTB predicted-taken flag for pc_in
stall  input  6  pipeline stall vector; stall[1] high = IF/ID will not accept
incorrect  input  1  branch redirect; kill in-flight fetch
mem_grant  input  1  memory controller grants the byte port; stays high until mem_req drops
mem_din  input  8  read byte; valid one cycle after its address is driven
mem_req  output  1  request for the byte port
mem_addr  output  32  byte address driven while granted
stallreq  output  1  combinational stall request to stall controller
inst_out  output  32  fetched instruction
pc_out  output  32  PC of inst_out
pre_to_take_out  output  1  prediction flag of inst_out

Behaviour:
- Reset: state=IDLE, all valid bits 0, mem_req=0, mem_addr=0, inst_out=0, pc_out=0, pre_to_take_out=0. Reset takes effect at the next edge, including mid-miss; a partially assembled word is discarded.
- Cache lookup is combinational on pc_in: hit = valid[idx] && tag[idx]==pc_in[17:IDX_W+2].
- Hit, with stall[1]=0:
  - Next edge registers inst_out, pc_out and pre_to_take_out. Latency 1, no stall.
  - stallreq=0.
- Miss, state machine IDLE -> WAIT -> B0 -> B1 -> B2 -> B3 -> B4 -> IDLE:
  - IDLE: on a miss, latch pc_in as fetch_pc, set mem_req=1, go to WAIT.
  - WAIT: hold until mem_grant=1. In the same cycle grant is seen, drive mem_addr=fetch_pc and go to B0.
  - B0..B2: drive mem_addr=fetch_pc+1..+3 respectively. Capture mem_din into byte 0..2.
  - B3: capture byte 3 from mem_din and drop mem_req. At the edge, write the line (valid=1, tag, data). If stall[1]=0, also register the outputs. Go to B4.
  - B4: one-cycle settle, then return to IDLE. The now-hitting pc_in is served normally.
- stallreq = 1 whenever pc_in misses and the final capture of that same pc is not occurring this cycle. It is 0 in the B3 cycle when fetch_pc==pc_in.
- Byte order: inst = {b3,b2,b1,b0}. All address arithmetic is 32-bit and wraps mod 2^32.
- stall[1]=1: output registers hold their values. The cache fill still completes.
- incorrect=1 in any state: next state is IDLE, mem_req=0, no cache write. Outputs are registered as a bubble: inst_out=0, pc_out=0, pre_to_take_out=0.
- incorrect takes priority over miss completion in the same cycle. rst_in takes priority over everything.
- pc_in changing mid-miss without incorrect is illegal: PC is held by stallreq.
- rdy_in=0 freezes the FSM, cache and outputs. mem_req and mem_addr hold.

Optional Feature:
ICACHE_EN
- Defined: cache arrays present; behaviour as above.
- Undefined: no arrays; every fetch takes the miss path (minimum 6 cycles) and nothing is written. Ports are unchanged, and parameters are accepted but unused.

Test Plan:
1. Cold miss: reset, pc_in=0x0, memory bytes 0x13,0x05,0x10,0x00, grant returned after 2 cycles -> mem_addr sequence 0x0,0x1,0x2,0x3; stallreq high until the B3 cycle; inst_out=0x00100513, pc_out=0x0.
2. Hit after fill: re-present pc_in=0x0 with pre_to_take_in=1 -> inst_out=0x00100513 one edge later; stallreq=0; mem_req stays 0; pre_to_take_out=1.
3. Conflict: fill 0x0, then fetch 0x200 (same index, ICACHE_LINES=128) -> miss; line replaced; a later fetch of 0x0 misses again.
4. Redirect mid-miss: incorrect=1 during B1 -> next cycle IDLE, mem_req=0, inst_out=0, no cache write; a refetch of the same pc still misses.
5. Downstream stall: stall[1]=1 during a hit sequence -> inst_out/pc_out hold the previous values until stall[1] falls.
6. Reset mid-miss at B2 -> all valid bits cleared; outputs zero; mem_req=0 after the edge.
